// File: rtl/gf2_restrict_encoder.sv
// gf2_restrict_encoder: computes y = A*x over GF(2), one result row per clock.
// Matrix A is held in a row-programmable register file that resets to identity.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and data steady until that edge. in_ready is
// high only in IDLE. out_valid stays high with out_vec frozen in HOLD until
// out_ready is seen. A new vector is accepted no earlier than the cycle after
// the output handshake.
module gf2_restrict_encoder #(
    parameter int N  = 15,
    parameter int K  = 15,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_row,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_vec,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic [N-1:0]  ONE_HOT0 = N'(1);
    localparam logic [AW-1:0] LAST_ROW = AW'(K - 1);

    state_t        state;
    logic [N-1:0]  mat [K];
    logic [N-1:0]  xreg;
    logic [K-1:0]  acc;
    logic [AW-1:0] r;
    logic          fin;     // last row has been folded into acc
    logic          row_ok;  // cfg_addr names an existing row
    logic          cfg_ok;  // config write is accepted this cycle

    // One extra address bit so K = 2^AW compares correctly.
    assign row_ok = ({1'b0, cfg_addr} < (AW+1)'(K));
    assign cfg_ok = cfg_we && (state == S_IDLE) && row_ok;

    // Matrix row storage; identity at reset, rows at or beyond N come out zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                mat[i] <= ONE_HOT0 << i;
            end
        end else if (cfg_ok) begin
            mat[cfg_addr] <= cfg_row;
        end
    end

    // Control FSM: capture x, fold one row parity per cycle, then hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_vec   <= '0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            xreg      <= '0;
            acc       <= '0;
            r         <= '0;
            fin       <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        xreg     <= in_vec;
                        acc      <= '0;
                        r        <= '0;
                        fin      <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (!fin) begin
                        acc[r] <= ^(mat[r] & xreg);
                        if (r == LAST_ROW) begin
                            fin <= 1'b1;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        out_vec   <= acc;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
